dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of ACCESS cycles waiting for mem_ready (range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 MemtoRegM  input  1  SHALL request a load for the instruction held in the M-stage register.
REQ-005 MemWriteM  input  1  SHALL request a store for the instruction held in the M-stage register.
REQ-006 ALUOutM  input  32  SHALL supply the byte address of the access.
REQ-007 WriteDataM  input  32  SHALL supply the store data.
REQ-008 err_clr  input  1  SHALL clear MemErr when high.
REQ-009 mem_ready  input  1  SHALL be the memory's completion strobe.
REQ-010 mem_rdata  input  32  SHALL be the load data, valid when mem_ready=1.
REQ-011 mem_req  output  1  SHALL be the registered request to memory.
REQ-012 mem_we  output  1  SHALL indicate a write request.
REQ-013 mem_addr  output  32  SHALL be the registered access address.
REQ-014 mem_wdata  output  32  SHALL be the registered store data.
REQ-015 ReadDataM  output  32  SHALL be the registered load result.
REQ-016 StallM  output  1  SHALL freeze the F/D/E/M pipeline registers when high.
REQ-017 MemErr  output  1  SHALL be a sticky error flag.

Function
REQ-018 Block SHALL implement an FSM with exactly three states: IDLE, ACCESS, and DONE.
REQ-019 In IDLE with MemtoRegM|MemWriteM=1, block SHALL assert StallM combinationally in the same cycle.
REQ-020 In IDLE with an aligned access (ALUOutM[1:0]=0), block SHALL go to ACCESS and register mem_addr<=ALUOutM, mem_wdata<=WriteDataM, mem_we<=MemWriteM, and mem_req<=1.
REQ-021 In IDLE with a misaligned access, block SHALL go directly to DONE, set MemErr, load ReadDataM<=0, and issue no request.
REQ-022 In IDLE with no access, StallM SHALL be 0 and the state SHALL remain IDLE.
REQ-023 When MemtoRegM and MemWriteM are both 1, block SHALL perform a write and load ReadDataM<=0 on completion.
REQ-024 In ACCESS, StallM and mem_req SHALL be 1, and mem_addr, mem_wdata and mem_we SHALL be held constant.
REQ-025 In ACCESS with mem_ready=1, block SHALL load ReadDataM<=mem_rdata (for reads; unchanged for writes), clear mem_req and mem_we, and go to DONE.
REQ-026 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with mem_ready=0.
REQ-027 When the counter reaches TIMEOUT, block SHALL set MemErr, load ReadDataM<=0, clear mem_req, and go to DONE.
REQ-028 mem_ready=1 on the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-029 In DONE, StallM SHALL be 0 for exactly one cycle so the pipeline advances; block SHALL issue no request and return to IDLE unconditionally.
REQ-030 mem_ready outside ACCESS SHALL be ignored.
REQ-031 Minimum access latency SHALL be 2 stalled cycles (IDLE, ACCESS) with mem_ready=1 on the first ACCESS cycle, then DONE.
REQ-032 Back-to-back accesses SHALL each pay the full sequence, with IDLE re-sampling only after DONE.
REQ-033 MemErr SHALL clear on err_clr=1.
REQ-034 If err_clr=1 and a set event occur in the same cycle, the set SHALL take priority.

Reset
REQ-035 While rst_n=0, state SHALL be IDLE, the counter 0, and mem_req, mem_we, mem_addr, mem_wdata, ReadDataM and MemErr all 0.
REQ-036 Reset asserted mid-ACCESS SHALL drop mem_req asynchronously, with no completion recorded.
REQ-037 After reset, StallM SHALL follow REQ-019/REQ-022 purely from the inputs.

Verification
REQ-038 Load: MemtoRegM=1 with ALUOutM=0x100 and mem_ready=1 on the 1st ACCESS cycle with mem_rdata=0xCAFEF00D -> StallM=1 for 2 cycles and ReadDataM=0xCAFEF00D in DONE.
REQ-039 Store: MemWriteM=1 with ALUOutM=0x204, WriteDataM=0x12345678, and mem_ready delayed 3 cycles -> mem_req=1 with mem_we=1 and addr/wdata stable for 4 cycles, then StallM=0 in DONE.
REQ-040 Timeout: TIMEOUT=15 with mem_ready held at 0 -> 15 ACCESS cycles, then MemErr=1 and ReadDataM=0; err_clr pulse -> MemErr=0.
REQ-041 Misaligned: MemtoRegM=1 with ALUOutM=0x102 -> mem_req never asserted, StallM=1 for 1 cycle, and MemErr=1.
REQ-042 Reset mid-ACCESS: rst_n=0 on the 2nd ACCESS cycle -> mem_req=0 immediately; after release, state is IDLE and all outputs are 0.
REQ-043 Back-to-back: two consecutive loads with immediate mem_ready -> stall pattern 1,1,0,1,1,0 and two distinct ReadDataM values captured.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Memory-side bus between the M-stage data-memory controller and the data memory.
// The controller drives the request side; the memory returns a ready strobe and load data.
interface dmem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory access controller: stalls the pipeline while a load/store waits on
// memory, bounds the wait with a timeout, and flags misaligned or timed-out accesses.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       MemtoRegM,
  input  logic                       MemWriteM,
  input  logic [31:0]                ALUOutM,
  input  logic [31:0]                WriteDataM,
  input  logic                       err_clr,
  output logic [31:0]                ReadDataM,
  output logic                       StallM,
  output logic                       MemErr,
  dmem_access_ctrl_if.master         mem
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_is_load;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_read_data;
  logic        r_mem_err;

  logic        w_access;
  logic        w_aligned;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_err_set;

  assign w_access  = MemtoRegM | MemWriteM;
  assign w_aligned = (ALUOutM[1:0] == 2'b00);
  assign w_cnt_inc = r_wait_cnt + 8'd1;
  // A ready strobe on the last permitted cycle wins over the timeout.
  assign w_timeout = !mem.mem_ready && (w_cnt_inc == TIMEOUT_C);
  assign w_err_set = ((r_state == S_IDLE) && w_access && !w_aligned) ||
                     ((r_state == S_ACCESS) && w_timeout);

  // Stall must rise in the same cycle the request is seen, so it is decoded, not registered.
  assign StallM = ((r_state == S_IDLE) && w_access) || (r_state == S_ACCESS);

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 8'd0;
      r_is_load   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_read_data <= 32'd0;
      r_mem_err   <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end else if (err_clr) begin
        r_mem_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_aligned) begin
              r_state     <= S_ACCESS;
              r_wait_cnt  <= 8'd0;
              r_is_load   <= MemtoRegM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= MemWriteM;
              r_mem_addr  <= ALUOutM;
              r_mem_wdata <= WriteDataM;
            end else begin
              r_state     <= S_DONE;
              r_read_data <= 32'd0;
            end
          end
        end

        S_ACCESS: begin
          if (mem.mem_ready) begin
            // Load+store together is treated as a store whose load result reads as zero.
            if (r_mem_we) begin
              if (r_is_load) begin
                r_read_data <= 32'd0;
              end
            end else begin
              r_read_data <= mem.mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            r_wait_cnt  <= w_cnt_inc;
            r_read_data <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_wait_cnt <= w_cnt_inc;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign ReadDataM     = r_read_data;
  assign MemErr        = r_mem_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized transactions, each
// expanded by a transaction-level model into the expected per-cycle stall/request trace.
module tb_dmem_access_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoRegM, MemWriteM, err_clr;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MemErr;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .err_clr    (err_clr),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MemErr     (MemErr),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs for the cycle about to be sampled.
  logic        exp_stall, exp_req, exp_we, exp_in_acc;
  logic [31:0] exp_addr, exp_wdata;
  // Architectural state carried across cycles.
  logic [31:0] exp_rd;
  logic        exp_err;
  bit          rand_clr;
  bit          force_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic noise();
    err_clr       = rand_clr ? ($urandom_range(0, 3) == 0) : force_clr;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
  endtask

  // Compare this cycle, then advance the model across the clock edge.
  task automatic check_cycle(input bit set_evt, input bit rd_upd, input logic [31:0] rd_val);
    @(negedge clk);
    check("stall", StallM, exp_stall);
    check("req", bus.mem_req, exp_req);
    check("we", bus.mem_we, exp_we);
    check("rdata", ReadDataM, exp_rd);
    check("err", MemErr, exp_err);
    if (exp_in_acc) begin
      check("addr", bus.mem_addr, exp_addr);
      check("wdata", bus.mem_wdata, exp_wdata);
    end
    if (set_evt) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
    if (rd_upd) exp_rd = rd_val;
    @(posedge clk);
    #1;
  endtask

  // One pipeline instruction in M: IDLE cycle, optional ACCESS cycles, DONE cycle.
  // delay = number of not-ready ACCESS cycles before memory answers (>= TO means timeout).
  task automatic run_txn(input bit ld, input bit st, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay, input logic [31:0] rd);
    bit acc;
    bit aligned;
    acc       = ld | st;
    aligned   = (addr[1:0] == 2'b00);
    MemtoRegM = ld;
    MemWriteM = st;
    ALUOutM   = addr;
    WriteDataM = wd;

    noise();
    exp_stall = acc; exp_req = 1'b0; exp_we = 1'b0; exp_in_acc = 1'b0;
    check_cycle(acc && !aligned, acc && !aligned, 32'h0);
    if (!acc) return;

    if (aligned) begin
      for (int k = 0; k < TO; k++) begin
        noise();
        bus.mem_ready = (k == delay);
        if (k == delay) bus.mem_rdata = rd;
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = st; exp_in_acc = 1'b1;
        exp_addr = addr; exp_wdata = wd;
        if (k == delay) begin
          check_cycle(1'b0, ld, st ? 32'h0 : rd);
          break;
        end else if (k == TO - 1) begin
          check_cycle(1'b1, 1'b1, 32'h0);
        end else begin
          check_cycle(1'b0, 1'b0, 32'h0);
        end
      end
    end

    noise();
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_in_acc = 1'b0;
    check_cycle(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    MemtoRegM = 1'b0; MemWriteM = 1'b0; err_clr = 1'b0;
    ALUOutM = '0; WriteDataM = '0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    exp_rd = '0; exp_err = 1'b0; rand_clr = 1'b0; force_clr = 1'b0;
    exp_addr = '0; exp_wdata = '0;

    // Reset values, and stall decoded purely from inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_err", MemErr, 0);
    check("rst_stall", StallM, 0);
    MemtoRegM = 1'b1;
    #1 check("rst_stall_req", StallM, 1);
    MemtoRegM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed load with immediate ready.
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFE_F00D);
    check("load_result", ReadDataM, 32'hCAFE_F00D);

    // Directed store, ready after three waits.
    run_txn(1'b0, 1'b1, 32'h204, 32'h1234_5678, 3, 32'hDEAD_BEEF);
    check("store_keeps_rdata", ReadDataM, 32'hCAFE_F00D);

    // Load+store together: write performed, load result reads zero.
    run_txn(1'b1, 1'b1, 32'h208, 32'hA5A5_0001, 1, 32'h7777_7777);
    check("both_rdata_zero", ReadDataM, 0);

    // Timeout, then clear.
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, 99, 32'h0);
    check("timeout_err", MemErr, 1);
    check("timeout_rdata", ReadDataM, 0);
    force_clr = 1'b1;
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    force_clr = 1'b0;
    check("err_cleared", MemErr, 0);

    // Ready on the very last allowed cycle counts as success.
    run_txn(1'b1, 1'b0, 32'h310, 32'h0, TO - 1, 32'h0BAD_CAFE);
    check("late_ready_ok", MemErr, 0);
    check("late_ready_data", ReadDataM, 32'h0BAD_CAFE);

    // Misaligned, then misaligned with a simultaneous clear (set wins).
    run_txn(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h0);
    check("misalign_err", MemErr, 1);
    force_clr = 1'b1;
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h401, 32'h5, 0, 32'h0);
    force_clr = 1'b0;

    // Back-to-back loads.
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h1111_2222);
    check("b2b_first", ReadDataM, 32'h1111_2222);
    run_txn(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'h3333_4444);
    check("b2b_second", ReadDataM, 32'h3333_4444);

    // Reset during the second ACCESS cycle.
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    MemtoRegM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h40;
    noise();
    exp_stall = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_in_acc = 1'b0;
    check_cycle(1'b0, 1'b0, 32'h0);
    noise(); bus.mem_ready = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b1; exp_in_acc = 1'b1; exp_addr = 32'h40; exp_wdata = WriteDataM;
    check_cycle(1'b0, 1'b0, 32'h0);
    bus.mem_ready = 1'b0;
    #1 check("pre_rst_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1 check("async_rst_req", bus.mem_req, 0);
    check("async_rst_rdata", ReadDataM, 0);
    check("async_rst_err", MemErr, 0);
    MemtoRegM = 1'b0; err_clr = 1'b0;
    exp_rd = '0; exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h5555_6666);

    // Randomized transactions.
    rand_clr = 1'b1;
    for (int t = 0; t < 80; t++) begin
      int kind;
      int delay;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      delay = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 3);
      run_txn(kind[0], kind[1], addr, $urandom, delay, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
